dm_stage: RTL and testbench

- M-stage data memory, directly downstream of the E-to-M pipeline register.
- Consumes MemAddr (ALU result), WriteData (forwarded rt value) and a decoded memory-op code.
- Performs word, halfword and byte loads and stores on a little-endian word-organised RAM.
- Flags misaligned or out-of-range accesses. Load data goes to the M-to-W register.

---
 rtl/dm_stage.sv | 144 ++++++++++++++
 tb/tb_dm_stage.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_stage.sv
// ---------------------------------------------------------------------------
// dm_stage -- M-stage data memory
//
// Word-organised, little-endian data RAM sitting directly behind the E-to-M
// pipeline register. Serves word / halfword / byte loads (sign- or
// zero-extended) combinationally from the current contents and commits
// stores on the rising clock edge. Misaligned or out-of-range accesses raise
// an address-error flag and have no effect on memory.
//
// Parameters:
//   DEPTH  number of 32-bit words; valid bytes are BASE .. BASE+4*DEPTH-1
//   BASE   byte address of word 0 (word-aligned)
//
// Ports:
//   clk       clock, all state changes on posedge
//   reset     synchronous active-high reset, clears every word in one cycle
//   mem_op    0=NONE 1=LW 2=LH 3=LHU 4=LB 5=LBU 6=SW 7=SH 8=SB, 9-15=NONE
//   addr      byte address (MemAddr)
//   wdata     store data; low halfword/byte used by SH/SB
//   pc        PC of the M-stage instruction, used only by the write log
//   rdata     extended load result (combinational)
//   exc_adel  load address error (combinational)
//   exc_ades  store address error (combinational)
//
// Optional feature macro: DM_WRITE_LOG_EN
//   When defined, every committed store prints one line with time, pc,
//   word address and the full merged word. Functionally identical otherwise.
// ---------------------------------------------------------------------------
module dm_stage #(
    parameter int          DEPTH = 3072,
    parameter logic [31:0] BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    output logic [31:0] rdata,
    output logic        exc_adel,
    output logic        exc_ades
);

    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    logic [31:0] mem [DEPTH];

    logic [31:0] offset;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        is_load;
    logic        is_store;
    logic        aligned;
    logic [31:0] cur_word;
    logic [31:0] merged;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        store_en;

    // Address decode. Out-of-range addresses read as zero so the word index
    // is never used to look past the end of the array.
    always_comb begin
        offset   = addr - BASE;
        in_range = (addr >= BASE) && (offset < SPAN);
        idx      = offset[AW+1:2];
        cur_word = in_range ? mem[idx] : 32'h0;
    end

    // Op classification and alignment; undefined codes fall to the default
    // and behave exactly like NONE.
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        aligned  = 1'b1;
        case (mem_op)
            OP_LW:          begin is_load  = 1'b1; aligned = (addr[1:0] == 2'b00); end
            OP_LH, OP_LHU:  begin is_load  = 1'b1; aligned = (addr[0] == 1'b0);    end
            OP_LB, OP_LBU:  begin is_load  = 1'b1;                                end
            OP_SW:          begin is_store = 1'b1; aligned = (addr[1:0] == 2'b00); end
            OP_SH:          begin is_store = 1'b1; aligned = (addr[0] == 1'b0);    end
            OP_SB:          begin is_store = 1'b1;                                end
            default:        ;
        endcase
    end

    assign exc_adel = is_load  && (!aligned || !in_range);
    assign exc_ades = is_store && (!aligned || !in_range);
    assign store_en = is_store && !exc_ades;

    assign byte_lane = cur_word[{addr[1:0], 3'b000} +: 8];
    assign half_lane = cur_word[{addr[1], 4'b0000} +: 16];

    // Load result, extended per op; faulting or non-load ops return zero.
    always_comb begin
        rdata = 32'h0;
        if (is_load && !exc_adel) begin
            case (mem_op)
                OP_LW:   rdata = cur_word;
                OP_LH:   rdata = {{16{half_lane[15]}}, half_lane};
                OP_LHU:  rdata = {16'h0, half_lane};
                OP_LB:   rdata = {{24{byte_lane[7]}}, byte_lane};
                OP_LBU:  rdata = {24'h0, byte_lane};
                default: rdata = 32'h0;
            endcase
        end
    end

    // Read-modify-write merge: untouched lanes keep their current contents.
    always_comb begin
        merged = cur_word;
        case (mem_op)
            OP_SW:   merged = wdata;
            OP_SH:   merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
            OP_SB:   merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
            default: ;
        endcase
    end

    // Reset clears the whole array and takes priority over any store in the
    // same cycle. Loads see pre-edge contents because the write lands here.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0;
            end
        end else if (store_en) begin
            mem[idx] <= merged;
`ifdef DM_WRITE_LOG_EN
            $display("%d@%h: *%h <= %h", $time, pc, {addr[31:2], 2'b00}, merged);
`endif
        end
    end

endmodule

// File: tb/tb_dm_stage.sv
// ---------------------------------------------------------------------------
// tb_dm_stage -- self-checking bench for dm_stage
//
// A byte-addressed reference memory tracks every committed store; loads and
// error flags are predicted from it with plain arithmetic and checked on
// every negedge. A directed sequence of literal expectations pins the model,
// followed by a randomized phase with occasional resets.
// ---------------------------------------------------------------------------
module tb_dm_stage;

    localparam int          DEPTH = 3072;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          NBYTE = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  mem_op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        exc_adel;
    logic        exc_ades;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    logic [7:0] model_mem [NBYTE];

    always #5 clk = ~clk;

    dm_stage #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk      (clk),
        .reset    (reset),
        .mem_op   (mem_op),
        .addr     (addr),
        .wdata    (wdata),
        .pc       (pc),
        .rdata    (rdata),
        .exc_adel (exc_adel),
        .exc_ades (exc_ades)
    );

    // Access size in bytes for an op code, 0 for anything that is not a
    // memory access.
    function automatic int op_size(input logic [3:0] op);
        case (op)
            4'd1, 4'd6:       return 4;
            4'd2, 4'd3, 4'd7: return 2;
            4'd4, 4'd5, 4'd8: return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    function automatic bit access_ok(input logic [3:0] op, input logic [31:0] a);
        longint off;
        int     sz;
        sz  = op_size(op);
        off = longint'(a) - longint'(BASE);
        if (off < 0 || off >= NBYTE) return 1'b0;
        return (a % sz) == 0;
    endfunction

    // Expected outputs from the byte model for the current inputs.
    task automatic model_eval(input logic [3:0] op, input logic [31:0] a,
                              output logic [31:0] rd, output logic el, output logic es);
        int          sz;
        int          off;
        logic [31:0] v;
        rd = 32'h0;
        el = 1'b0;
        es = 1'b0;
        sz = op_size(op);
        if (op_is_load(op)) begin
            if (!access_ok(op, a)) begin
                el = 1'b1;
            end else begin
                off = int'(a - BASE);
                v   = 32'h0;
                for (int i = 0; i < sz; i++) v = v | (32'(model_mem[off + i]) << (8 * i));
                if (op == 4'd2 && v[15]) v = v | 32'hFFFF_0000;
                if (op == 4'd4 && v[7])  v = v | 32'hFFFF_FF00;
                rd = v;
            end
        end else if (op_is_store(op)) begin
            es = !access_ok(op, a);
        end
    endtask

    // Reference memory update, one step per rising edge.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBYTE; i++) model_mem[i] = 8'h00;
        end else if (op_is_store(mem_op) && access_ok(mem_op, addr)) begin
            for (int i = 0; i < op_size(mem_op); i++)
                model_mem[int'(addr - BASE) + i] = wdata[8*i +: 8];
        end
    end

    // Continuous comparison of the DUT against the model.
    always @(negedge clk) begin
        logic [31:0] exp_rd;
        logic        exp_el;
        logic        exp_es;
        if (check_en) begin
            model_eval(mem_op, addr, exp_rd, exp_el, exp_es);
            tests++;
            if (rdata !== exp_rd || exc_adel !== exp_el || exc_ades !== exp_es) begin
                fails++;
                $display("[TB] FAIL model op=%0d addr=%h: got rdata=%h adel=%b ades=%b, expected rdata=%h adel=%b ades=%b",
                         mem_op, addr, rdata, exc_adel, exc_ades, exp_rd, exp_el, exp_es);
            end
        end
    end

    // Drive one instruction for one cycle and settle past the negedge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic rst);
        @(posedge clk);
        #1;
        mem_op = op;
        addr   = a;
        wdata  = wd;
        reset  = rst;
        pc     = pc + 32'd4;
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] exp_rd,
                               input logic exp_el, input logic exp_es);
        tests++;
        if (rdata !== exp_rd || exc_adel !== exp_el || exc_ades !== exp_es) begin
            fails++;
            $display("[TB] FAIL %s: got rdata=%h adel=%b ades=%b, expected rdata=%h adel=%b ades=%b",
                     name, rdata, exc_adel, exc_ades, exp_rd, exp_el, exp_es);
        end
    endtask

    initial begin
        logic [31:0] ra;
        int          sel;
        reset  = 1'b1;
        mem_op = 4'd0;
        addr   = 32'h0;
        wdata  = 32'h0;
        pc     = 32'h0040_0000;

        // Reset, then loads at both ends of memory read zero.
        applyStimulus(4'd0, 32'h0, 32'h0, 1'b1);
        check_en = 1'b1;
        applyStimulus(4'd1, 32'h0000_0000, 32'h0, 1'b0);
        checkOutput("lw_low_after_reset", 32'h0, 1'b0, 1'b0);
        applyStimulus(4'd1, 32'h0000_2FFC, 32'h0, 1'b0);
        checkOutput("lw_top_after_reset", 32'h0, 1'b0, 1'b0);

        // Word store then readback.
        applyStimulus(4'd6, 32'h10, 32'h1234_5678, 1'b0);
        checkOutput("sw_cycle_outputs", 32'h0, 1'b0, 1'b0);
        applyStimulus(4'd1, 32'h10, 32'h0, 1'b0);
        checkOutput("lw_after_sw", 32'h1234_5678, 1'b0, 1'b0);

        // Byte store into lane 1.
        applyStimulus(4'd8, 32'h11, 32'h0000_00AB, 1'b0);
        applyStimulus(4'd1, 32'h10, 32'h0, 1'b0);
        checkOutput("lw_after_sb", 32'h1234_AB78, 1'b0, 1'b0);
        applyStimulus(4'd4, 32'h11, 32'h0, 1'b0);
        checkOutput("lb_sign", 32'hFFFF_FFAB, 1'b0, 1'b0);
        applyStimulus(4'd5, 32'h11, 32'h0, 1'b0);
        checkOutput("lbu_zero", 32'h0000_00AB, 1'b0, 1'b0);

        // Halfword store into the upper lane.
        applyStimulus(4'd7, 32'h12, 32'h0000_8001, 1'b0);
        applyStimulus(4'd1, 32'h10, 32'h0, 1'b0);
        checkOutput("lw_after_sh", 32'h8001_AB78, 1'b0, 1'b0);
        applyStimulus(4'd2, 32'h12, 32'h0, 1'b0);
        checkOutput("lh_sign", 32'hFFFF_8001, 1'b0, 1'b0);
        applyStimulus(4'd3, 32'h12, 32'h0, 1'b0);
        checkOutput("lhu_zero", 32'h0000_8001, 1'b0, 1'b0);

        // Error cases; the word at 0x10 must survive all of them.
        applyStimulus(4'd6, 32'h13, 32'hFFFF_FFFF, 1'b0);
        checkOutput("sw_misaligned", 32'h0, 1'b0, 1'b1);
        applyStimulus(4'd7, 32'h11, 32'hFFFF_FFFF, 1'b0);
        checkOutput("sh_misaligned", 32'h0, 1'b0, 1'b1);
        applyStimulus(4'd1, 32'h3000, 32'h0, 1'b0);
        checkOutput("lw_out_of_range", 32'h0, 1'b1, 1'b0);
        applyStimulus(4'd2, 32'h13, 32'h0, 1'b0);
        checkOutput("lh_misaligned", 32'h0, 1'b1, 1'b0);
        applyStimulus(4'd6, 32'h3000, 32'hFFFF_FFFF, 1'b0);
        checkOutput("sw_out_of_range", 32'h0, 1'b0, 1'b1);
        applyStimulus(4'd9, 32'h10, 32'hFFFF_FFFF, 1'b0);
        checkOutput("undefined_op", 32'h0, 1'b0, 1'b0);
        applyStimulus(4'd1, 32'h10, 32'h0, 1'b0);
        checkOutput("word_kept_after_errors", 32'h8001_AB78, 1'b0, 1'b0);

        // Reset beats a simultaneous store and clears everything.
        applyStimulus(4'd6, 32'h20, 32'hDEAD_BEEF, 1'b1);
        applyStimulus(4'd1, 32'h20, 32'h0, 1'b0);
        checkOutput("reset_beats_store", 32'h0, 1'b0, 1'b0);
        applyStimulus(4'd1, 32'h10, 32'h0, 1'b0);
        checkOutput("reset_clears_all", 32'h0, 1'b0, 1'b0);

        // Randomized traffic focused on a small window for lane collisions,
        // with some accesses near the top boundary and anywhere in 32 bits.
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 7)       ra = 32'($urandom_range(0, 255));
            else if (sel < 9)  ra = 32'h2FF0 + 32'($urandom_range(0, 31));
            else               ra = $urandom;
            applyStimulus(4'($urandom_range(0, 15)), ra, $urandom,
                          ($urandom_range(0, 199) == 0));
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
